// File: rtl/my_rst_pkg.sv
// -----------------------------------------------------------------------------
// my_rst_pkg
// Shared types and helpers for the staged reset sequencer.
//   seq_state_e : sequencer FSM states
//   MAX_STAGES  : upper bound on the number of staged reset outputs
//   cnt_width() : width of a counter that must reach max(a, b)
// -----------------------------------------------------------------------------
package my_rst_pkg;

  typedef enum logic [1:0] {
    SEQ_RST = 2'd0,
    SEQ     = 2'd1,
    DONE    = 2'd2,
    SOFT    = 2'd3
  } seq_state_e;

  localparam int MAX_STAGES = 8;

  function automatic int cnt_width(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/my_delay_counter.sv
// -----------------------------------------------------------------------------
// my_delay_counter
// Loadable up-counter used for both the stage spacing and the soft-reset
// hold time. Counts from 1; hit flags the cycle on which count equals limit
// and the counter is not frozen.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   clear : reload the count to 1 on the next edge
//   hold  : freeze the count (also suppresses hit)
//   limit : terminal count
//   hit   : count == limit and not held
// -----------------------------------------------------------------------------
module my_delay_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] count;

  // The reset value is 1 rather than 0 so that the edge on which rst_n is
  // first seen high already counts as the first delay cycle; that places the
  // first release STAGE_DLY-1 edges after reset exit, while every later
  // interval is a full STAGE_DLY edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= CNT_W'(1);
    end else if (clear) begin
      count <= CNT_W'(1);
    end else if (!hold) begin
      count <= count + CNT_W'(1);
    end
  end

  assign hit = !hold && (count == limit);

endmodule

// File: rtl/my_reset_sequencer.sv
// -----------------------------------------------------------------------------
// my_reset_sequencer
// Releases NUM_STAGES active-low resets one after another, STAGE_DLY cycles
// apart, then raises sys_ready. From the ready state a soft reset request
// pulls every stage back into reset for SOFT_RST_LEN cycles and re-runs the
// sequence without touching rst_n.
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset, overrides everything
//   seq_hold    : freezes the delay counter while high
//   soft_req    : soft-reset request (only honoured when ready)
//   soft_ack    : one-cycle acknowledge of an accepted request
//   stage_rst_n : staged active-low resets, bit k released k-th
//   sys_ready   : all stages released and no soft reset in progress
//   stage_idx   : next stage to release, 0 when idle or done
// All outputs are registered.
// -----------------------------------------------------------------------------
module my_reset_sequencer
  import my_rst_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int STAGE_DLY    = 16,
  parameter int SOFT_RST_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seq_hold,
  input  logic                  soft_req,
  output logic                  soft_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  sys_ready,
  output logic [2:0]            stage_idx
);

  localparam int CNT_W = cnt_width(STAGE_DLY, SOFT_RST_LEN);
  localparam logic [CNT_W-1:0] STAGE_LIM = CNT_W'(STAGE_DLY);
  localparam logic [CNT_W-1:0] SOFT_LIM  = CNT_W'(SOFT_RST_LEN);
  localparam logic [2:0]       LAST_IDX  = 3'(NUM_STAGES - 1);

  seq_state_e            state, state_next;
  logic [NUM_STAGES-1:0] stage_next;
  logic [2:0]            idx_next;
  logic                  ready_next;
  logic                  ack_next;

  logic                  cnt_clear;
  logic                  cnt_hold;
  logic [CNT_W-1:0]      cnt_limit;
  logic                  cnt_hit;
  logic [NUM_STAGES-1:0] release_mask;

  // One-hot mask selecting the stage that is released next.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
    assign release_mask[gi] = (stage_idx == 3'(gi));
  end

  // Counter control depends only on state and seq_hold, never on hit, so it
  // is kept outside the FSM block to avoid a combinational loop through hit.
  // The reset-exit edge always counts; in DONE the counter is parked.
  assign cnt_hold  = (state == SEQ_RST) ? 1'b0 :
                     (state == DONE)    ? 1'b1 : seq_hold;
  assign cnt_limit = (state == SOFT) ? SOFT_LIM : STAGE_LIM;

  my_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .hold  (cnt_hold),
    .limit (cnt_limit),
    .hit   (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SEQ_RST;
      stage_rst_n <= '0;
      stage_idx   <= 3'd0;
      sys_ready   <= 1'b0;
      soft_ack    <= 1'b0;
    end else begin
      state       <= state_next;
      stage_rst_n <= stage_next;
      stage_idx   <= idx_next;
      sys_ready   <= ready_next;
      soft_ack    <= ack_next;
    end
  end

  always_comb begin
    state_next = state;
    stage_next = stage_rst_n;
    idx_next   = stage_idx;
    ready_next = sys_ready;
    ack_next   = 1'b0;
    cnt_clear  = 1'b0;
    case (state)
      SEQ_RST: begin
        state_next = SEQ;
      end
      SEQ: begin
        if (cnt_hit) begin
          stage_next = stage_rst_n | release_mask;
          cnt_clear  = 1'b1;
          if (stage_idx == LAST_IDX) begin
            // Ready rises on the same edge as the last stage release.
            state_next = DONE;
            idx_next   = 3'd0;
            ready_next = 1'b1;
          end else begin
            idx_next = stage_idx + 3'd1;
          end
        end
      end
      DONE: begin
        // Leaving DONE on the ack guarantees one ack per DONE visit even
        // when soft_req is held high.
        if (soft_req) begin
          state_next = SOFT;
          stage_next = '0;
          ready_next = 1'b0;
          ack_next   = 1'b1;
          cnt_clear  = 1'b1;
        end
      end
      SOFT: begin
        if (cnt_hit) begin
          state_next = SEQ;
          idx_next   = 3'd0;
          cnt_clear  = 1'b1;
        end
      end
      default: begin
        state_next = SEQ_RST;
      end
    endcase
  end

endmodule
